// File: rtl/tt_ctrl_sel.sv
// tt_ctrl_sel: design-select controller driven by three raw control pads.
// Each pad is synchronized, then glitch-filtered. The filtered levels drive a
// saturating select address with an increment strobe, a sticky overflow flag,
// and a registered enable for the selected design.
module tt_ctrl_sel #(
   parameter int ADDR_W     = 10,
   parameter int DEB_CYCLES = 4     // legal range 2..15 (4-bit filter counter)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              pad_sel_rst_n,
   input  logic              pad_sel_inc,
   input  logic              pad_ena,
   output logic [ADDR_W-1:0] sel_addr,
   output logic              sel_ena,
   output logic              inc_pulse,
   output logic              sel_ovf
);

   localparam int NPAD  = 3;
   localparam int P_RST = 0;
   localparam int P_INC = 1;
   localparam int P_ENA = 2;

   // Filter state flips on the DEB_CYCLES-th consecutive disagreeing edge.
   localparam logic [3:0]        CNT_LAST = 4'(DEB_CYCLES - 1);
   localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

   logic [NPAD-1:0]      pad;
   logic [NPAD-1:0]      sync1;
   logic [NPAD-1:0]      sync2;
   logic [NPAD-1:0]      filt;
   logic [NPAD-1:0][3:0] cnt;

   logic f_rst;
   logic f_inc;
   logic f_ena;

   logic inc_d;
   logic rst_d;
   logic inc_rise;

   logic [ADDR_W-1:0] addr_q;
   logic              ovf_q;
   logic              pulse_q;
   logic              ena_q;

   assign pad = {pad_ena, pad_sel_inc, pad_sel_rst_n};

   // Two-flop synchronizers; nothing downstream ever sees the raw pads.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync1 <= '0;
         sync2 <= '0;
      end else begin
         sync1 <= pad;
         sync2 <= sync1;
      end
   end

   // Per-pad glitch filter: count consecutive edges where the synchronized
   // level differs from the held level; any agreement restarts the count.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         filt <= '0;
         cnt  <= '0;
      end else begin
         for (int i = 0; i < NPAD; i++) begin
            if (sync2[i] == filt[i]) begin
               cnt[i] <= '0;
            end else if (cnt[i] == CNT_LAST) begin
               filt[i] <= sync2[i];
               cnt[i]  <= '0;
            end else begin
               cnt[i] <= cnt[i] + 4'd1;
            end
         end
      end
   end

   assign f_rst = filt[P_RST];
   assign f_inc = filt[P_INC];
   assign f_ena = filt[P_ENA];

   // Edge-detect history for the increment and the selection reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         inc_d <= 1'b0;
         rst_d <= 1'b0;
      end else begin
         inc_d <= f_inc;
         rst_d <= f_rst;
      end
   end

   // An increment edge only counts if the selection reset was released both
   // before and after that edge; an edge arriving together with the release
   // (e.g. both filters settling after rst_n) is discarded, never deferred.
   assign inc_rise = f_inc & ~inc_d & f_rst & rst_d;

   // Select address, overflow, strobe and enable state.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         addr_q  <= '0;
         ovf_q   <= 1'b0;
         pulse_q <= 1'b0;
         ena_q   <= 1'b0;
      end else begin
         ena_q <= f_ena & f_rst & ~ovf_q;
         if (!f_rst) begin
            addr_q  <= '0;
            ovf_q   <= 1'b0;
            pulse_q <= 1'b0;
         end else begin
            pulse_q <= inc_rise;
            if (inc_rise) begin
               if (addr_q == ADDR_MAX) begin
                  ovf_q <= 1'b1;
               end else begin
                  addr_q <= addr_q + ADDR_W'(1);
               end
            end
         end
      end
   end

   // Outputs come from flops only; the filtered selection reset masks them
   // immediately so they read zero for the whole time it is held low.
   assign sel_addr  = addr_q & {ADDR_W{f_rst}};
   assign sel_ovf   = ovf_q & f_rst;
   assign inc_pulse = pulse_q & f_rst;
   assign sel_ena   = ena_q;

endmodule

// File: tb/tb_tt_ctrl_sel.sv
// Bench for tt_ctrl_sel: two instances (10-bit and 3-bit address) share the
// pads. A reference model checks every cycle; directed table and sequences
// check absolute values.
module tb_tt_ctrl_sel;

   localparam int DEB = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic pad_sel_rst_n = 1'b1;
   logic pad_sel_inc = 1'b0;
   logic pad_ena = 1'b1;

   logic [9:0] a10;
   logic [2:0] a3;
   logic       e10, e3, p10, p3, o10, o3;

   always #5 clk = ~clk;

   tt_ctrl_sel #(.ADDR_W(10), .DEB_CYCLES(DEB)) dut (
      .clk(clk), .rst_n(rst_n), .pad_sel_rst_n(pad_sel_rst_n),
      .pad_sel_inc(pad_sel_inc), .pad_ena(pad_ena),
      .sel_addr(a10), .sel_ena(e10), .inc_pulse(p10), .sel_ovf(o10));

   tt_ctrl_sel #(.ADDR_W(3), .DEB_CYCLES(DEB)) dut3 (
      .clk(clk), .rst_n(rst_n), .pad_sel_rst_n(pad_sel_rst_n),
      .pad_sel_inc(pad_sel_inc), .pad_ena(pad_ena),
      .sel_addr(a3), .sel_ena(e3), .inc_pulse(p3), .sel_ovf(o3));

   int n_chk = 0;
   int n_fail = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // Pad index: 0 = sel_rst_n, 1 = sel_inc, 2 = ena. Filter rule: the held
   // level flips once the last DEB observed levels all differ from it and
   // at least DEB edges have passed since the previous flip.
   bit [2:0] m_s1, m_s2, m_f;
   int       m_since[3];
   int       m_hist[3];
   bit       m_fi_d, m_fr_d;
   int       m_addr[2];
   bit       m_ovf[2], m_pulse[2], m_ena[2];
   int       m_max[2] = '{1023, 7};

   task automatic model_step();
      bit [2:0] pad;
      bit fr, fi, fe, rise;
      int full;
      full = (1 << DEB) - 1;
      pad = {pad_ena, pad_sel_inc, pad_sel_rst_n};
      if (!rst_n) begin
         m_s1 = '0; m_s2 = '0; m_f = '0; m_fi_d = 0; m_fr_d = 0;
         for (int k = 0; k < 3; k++) begin m_since[k] = 0; m_hist[k] = 0; end
         for (int d = 0; d < 2; d++) begin
            m_addr[d] = 0; m_ovf[d] = 0; m_pulse[d] = 0; m_ena[d] = 0;
         end
         return;
      end
      fr = m_f[0]; fi = m_f[1]; fe = m_f[2];
      rise = fi && !m_fi_d && fr && m_fr_d;
      for (int d = 0; d < 2; d++) begin
         m_ena[d] = fe && fr && !m_ovf[d];
         if (!fr) begin
            m_addr[d] = 0; m_ovf[d] = 0; m_pulse[d] = 0;
         end else begin
            m_pulse[d] = rise;
            if (rise) begin
               if (m_addr[d] == m_max[d]) m_ovf[d] = 1;
               else m_addr[d] = m_addr[d] + 1;
            end
         end
      end
      m_fi_d = fi; m_fr_d = fr;
      for (int k = 0; k < 3; k++) begin
         m_since[k]++;
         m_hist[k] = ((m_hist[k] << 1) | int'(m_s2[k])) & full;
         if (m_since[k] >= DEB && m_hist[k] == (m_f[k] ? 0 : full)) begin
            m_f[k] = !m_f[k];
            m_since[k] = 0;
         end
      end
      m_s2 = m_s1;
      m_s1 = pad;
   endtask

   initial forever begin
      @(posedge clk);
      model_step();
   end

   // ---------------- per-cycle checker and pulse monitor ----------------
   bit   chk_en = 0;
   bit   mon_en = 0;
   int   pc10 = 0, pc3 = 0, coinc_err = 0, wide_err = 0;
   logic [9:0] last10 = '0;
   logic       lastp10 = 1'b0;

   initial forever begin
      @(negedge clk);
      if (chk_en) begin
         chk("model addr10", a10, m_f[0] ? m_addr[0] : 0);
         chk("model pulse10", p10, m_f[0] & m_pulse[0]);
         chk("model ovf10", o10, m_f[0] & m_ovf[0]);
         chk("model ena10", e10, m_ena[0]);
         chk("model addr3", a3, m_f[0] ? m_addr[1] : 0);
         chk("model pulse3", p3, m_f[0] & m_pulse[1]);
         chk("model ovf3", o3, m_f[0] & m_ovf[1]);
         chk("model ena3", e3, m_ena[1]);
      end
      pc10 += int'(p10 === 1'b1);
      pc3  += int'(p3 === 1'b1);
      if (mon_en) begin
         if ((a10 != last10) != p10) coinc_err++;
         if (p10 && lastp10) wide_err++;
      end
      last10  = a10;
      lastp10 = p10;
   end

   // ---------------- stimulus ----------------
   typedef struct {
      bit srst; bit inc; bit ena; int hold;
      int ea10; int ea3; bit eovf; bit eena;
   } vec_t;
   vec_t tbl[11];

   int base10, base3;
   int inc_left, srst_left, ena_left;

   task automatic pad_pulse(input int hi, input int lo);
      pad_sel_inc = 1'b1;
      repeat (hi) @(negedge clk);
      pad_sel_inc = 1'b0;
      repeat (lo) @(negedge clk);
   endtask

   task automatic clear_sel();
      pad_sel_rst_n = 1'b0;
      repeat (12) @(negedge clk);
      pad_sel_rst_n = 1'b1;
      repeat (12) @(negedge clk);
   endtask

   initial begin
      tbl[0]  = '{1, 1, 1, 12, 1, 1, 0, 1};
      tbl[1]  = '{1, 0, 1, 12, 1, 1, 0, 1};
      tbl[2]  = '{1, 1, 1, 12, 2, 2, 0, 1};
      tbl[3]  = '{1, 0, 0, 12, 2, 2, 0, 0};
      tbl[4]  = '{1, 1, 0, 12, 3, 3, 0, 0};
      tbl[5]  = '{0, 1, 0, 12, 0, 0, 0, 0};
      tbl[6]  = '{0, 0, 1, 12, 0, 0, 0, 0};
      tbl[7]  = '{1, 0, 1, 12, 0, 0, 0, 1};
      tbl[8]  = '{1, 1, 1, 12, 1, 1, 0, 1};
      tbl[9]  = '{0, 0, 1, 12, 0, 0, 0, 0};
      tbl[10] = '{1, 0, 1, 12, 0, 0, 0, 1};

      // Power-up: reset for 3 edges, then edge 0 is the first edge seeing rst_n=1.
      rst_n = 1'b0; pad_sel_rst_n = 1'b1; pad_ena = 1'b1; pad_sel_inc = 1'b0;
      repeat (3) @(negedge clk);
      chk_en = 1;
      rst_n = 1'b1;
      for (int k = 0; k <= 6; k++) begin
         @(negedge clk);
         chk("pwrup addr", a10, 0);
         chk("pwrup pulse", p10, 0);
         chk("pwrup ovf", o10, 0);
         chk("pwrup ena", e10, (k == 6));
      end

      // Table-driven level sequences.
      for (int i = 0; i < 11; i++) begin
         pad_sel_rst_n = tbl[i].srst;
         pad_sel_inc   = tbl[i].inc;
         pad_ena       = tbl[i].ena;
         repeat (tbl[i].hold) @(negedge clk);
         chk($sformatf("vec%0d addr10", i), a10, tbl[i].ea10);
         chk($sformatf("vec%0d addr3", i), a3, tbl[i].ea3);
         chk($sformatf("vec%0d ovf10", i), o10, tbl[i].eovf);
         chk($sformatf("vec%0d ena10", i), e10, tbl[i].eena);
         chk($sformatf("vec%0d pulse10", i), p10, 0);
      end

      // Counting: 7 clean pulses.
      base10 = pc10; coinc_err = 0; wide_err = 0; mon_en = 1;
      repeat (7) pad_pulse(10, 10);
      mon_en = 0;
      chk("count addr", a10, 7);
      chk("count pulses", pc10 - base10, 7);
      chk("count coincide", coinc_err, 0);
      chk("count width", wide_err, 0);

      // Glitch rejection: short high, then a short low gap inside a high period.
      base10 = pc10;
      pad_pulse(2, 12);
      chk("glitch hi pulses", pc10 - base10, 0);
      chk("glitch hi addr", a10, 7);
      pad_sel_inc = 1'b1; repeat (10) @(negedge clk);
      pad_sel_inc = 1'b0; repeat (3) @(negedge clk);
      pad_sel_inc = 1'b1; repeat (10) @(negedge clk);
      pad_sel_inc = 1'b0; repeat (12) @(negedge clk);
      chk("glitch lo pulses", pc10 - base10, 1);
      chk("glitch lo addr", a10, 8);

      // Saturation on the 3-bit instance.
      clear_sel();
      chk("sat clear addr3", a3, 0);
      repeat (8) pad_pulse(10, 10);
      chk("sat addr3", a3, 7);
      chk("sat ovf3", o3, 1);
      chk("sat ena3", e3, 0);
      chk("sat ena10", e10, 1);
      chk("sat addr10", a10, 8);
      base3 = pc3;
      pad_pulse(10, 10);
      chk("sat9 pulses3", pc3 - base3, 1);
      chk("sat9 addr3", a3, 7);
      chk("sat9 ovf3", o3, 1);

      // Priority: selection reset falls as the increment rises.
      clear_sel();
      repeat (5) pad_pulse(10, 10);
      chk("prio pre addr", a10, 5);
      base10 = pc10;
      pad_sel_rst_n = 1'b0; pad_sel_inc = 1'b1;
      repeat (20) @(negedge clk);
      chk("prio addr", a10, 0);
      pad_sel_rst_n = 1'b1;
      repeat (15) @(negedge clk);
      pad_sel_inc = 1'b0;
      repeat (15) @(negedge clk);
      chk("prio late addr", a10, 0);
      chk("prio pulses", pc10 - base10, 0);
      chk("prio ovf", o10, 0);

      // Reset in the middle of an increment.
      repeat (3) pad_pulse(10, 10);
      chk("rst pre addr", a10, 3);
      base10 = pc10;
      pad_sel_inc = 1'b1;
      repeat (2) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      chk("rst addr", a10, 0);
      repeat (7) @(negedge clk);
      pad_sel_inc = 1'b0;
      repeat (15) @(negedge clk);
      chk("rst post addr", a10, 0);
      chk("rst pulses", pc10 - base10, 0);
      pad_pulse(10, 10);
      chk("rst next addr", a10, 1);

      // Randomized runs of varying length on every pad, occasional rst_n.
      inc_left = 1; srst_left = 1; ena_left = 1;
      for (int c = 0; c < 4000; c++) begin
         @(negedge clk);
         if (!rst_n) rst_n = 1'b1;
         else if ($urandom_range(0, 499) == 0) rst_n = 1'b0;
         if (--inc_left == 0) begin
            pad_sel_inc = ~pad_sel_inc;
            inc_left = $urandom_range(1, 12);
         end
         if (--srst_left == 0) begin
            pad_sel_rst_n = ~pad_sel_rst_n;
            srst_left = pad_sel_rst_n ? $urandom_range(20, 300) : $urandom_range(1, 12);
         end
         if (--ena_left == 0) begin
            pad_ena = ~pad_ena;
            ena_left = $urandom_range(1, 40);
         end
      end
      repeat (10) @(negedge clk);
      chk_en = 0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
